// File: rtl/easyaxi_rd_arb_pkg.sv
// Shared AXI width/encoding macros and arbiter types for the easyaxi read arbiter.
// The macros are guarded so other easyaxi files may define the same set.
`ifndef EASYAXI_DEFINES
`define EASYAXI_DEFINES
`define AXI_ID_W     4
`define AXI_ADDR_W   32
`define AXI_LEN_W    8
`define AXI_SIZE_W   3
`define AXI_BURST_W  2
`define AXI_DATA_W   32
`define AXI_RESP_W   2
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`define AXI_SIZE_1B  3'b000
`define AXI_SIZE_2B  3'b001
`define AXI_SIZE_4B  3'b010
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_EXOKAY 2'b01
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

`ifndef AXI_ARB_IDX_W
`define AXI_ARB_IDX_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package easyaxi_rd_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/easyaxi_rr_pick.sv
// Combinational round-robin finder: first asserted req at or after ptr, wrapping
// modulo NUM_MST.
module easyaxi_rr_pick
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int IDX_W   = 1
)(
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_MST);
            if (!any && req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/easyaxi_rd_arb.sv
// N-to-1 AXI read arbiter: round-robin AR with grant lock, master index prefixed
// onto ARID, R beats routed back by RID prefix, per-master outstanding throttling.
module easyaxi_rd_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter  int NUM_MST   = 2,
    parameter  int OST_DEPTH = 4,
    localparam int IDX_W     = `AXI_ARB_IDX_W(NUM_MST),
    localparam int CNT_W     = $clog2(OST_DEPTH) + 1
)(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_MST-1:0]                 s_arvalid,
    output logic [NUM_MST-1:0]                 s_arready,
    input  logic [NUM_MST*`AXI_ID_W-1:0]       s_arid,
    input  logic [NUM_MST*`AXI_ADDR_W-1:0]     s_araddr,
    input  logic [NUM_MST*`AXI_LEN_W-1:0]      s_arlen,
    input  logic [NUM_MST*`AXI_SIZE_W-1:0]     s_arsize,
    input  logic [NUM_MST*`AXI_BURST_W-1:0]    s_arburst,
    output logic [NUM_MST-1:0]                 s_rvalid,
    input  logic [NUM_MST-1:0]                 s_rready,
    output logic [`AXI_ID_W-1:0]               s_rid,
    output logic [`AXI_DATA_W-1:0]             s_rdata,
    output logic [`AXI_RESP_W-1:0]             s_rresp,
    output logic                               s_rlast,
    output logic                               m_arvalid,
    input  logic                               m_arready,
    output logic [IDX_W+`AXI_ID_W-1:0]         m_arid,
    output logic [`AXI_ADDR_W-1:0]             m_araddr,
    output logic [`AXI_LEN_W-1:0]              m_arlen,
    output logic [`AXI_SIZE_W-1:0]             m_arsize,
    output logic [`AXI_BURST_W-1:0]            m_arburst,
    input  logic                               m_rvalid,
    output logic                               m_rready,
    input  logic [IDX_W+`AXI_ID_W-1:0]         m_rid,
    input  logic [`AXI_DATA_W-1:0]             m_rdata,
    input  logic [`AXI_RESP_W-1:0]             m_rresp,
    input  logic                               m_rlast,
    output logic [NUM_MST*CNT_W-1:0]           ost_cnt,
    output logic                               err
);

    arb_state_e       state, next_state;
    logic [IDX_W-1:0] grant, rr_ptr, pick_idx, r_idx;
    logic             pick_any, ar_hs, r_bad, r_last_hs, underflow;
    logic [NUM_MST-1:0] eligible, cnt_inc, cnt_dec;
    logic [CNT_W-1:0] cnt [NUM_MST];

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            eligible[k] = s_arvalid[k] && (cnt[k] < CNT_W'(OST_DEPTH));
        end
    end

    easyaxi_rr_pick #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && pick_any) begin
                grant <= pick_idx;
            end
            if (ar_hs) begin
                rr_ptr <= (int'(grant) == NUM_MST - 1) ? '0 : grant + IDX_W'(1);
            end
        end
    end

    // The grant stays locked until the downstream handshake; no re-arbitration in LOCK.
    always_comb begin
        next_state = state;
        m_arvalid  = 1'b0;
        s_arready  = '0;
        ar_hs      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) next_state = ARB_LOCK;
            end
            ARB_LOCK: begin
                m_arvalid        = 1'b1;
                s_arready[grant] = m_arready;
                ar_hs            = m_arready;
                if (m_arready) next_state = ARB_IDLE;
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        if (state == ARB_LOCK) begin
            m_arid    = {grant, s_arid[int'(grant)*`AXI_ID_W +: `AXI_ID_W]};
            m_araddr  = s_araddr[int'(grant)*`AXI_ADDR_W +: `AXI_ADDR_W];
            m_arlen   = s_arlen[int'(grant)*`AXI_LEN_W +: `AXI_LEN_W];
            m_arsize  = s_arsize[int'(grant)*`AXI_SIZE_W +: `AXI_SIZE_W];
            m_arburst = s_arburst[int'(grant)*`AXI_BURST_W +: `AXI_BURST_W];
        end
    end

    assign r_idx   = m_rid[`AXI_ID_W +: IDX_W];
    assign r_bad   = int'(r_idx) >= NUM_MST;
    assign s_rid   = m_rid[`AXI_ID_W-1:0];
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

    // Beats with an out-of-range prefix are swallowed so the slave never stalls on them.
    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b0;
        if (rst_n) begin
            if (r_bad) begin
                m_rready = 1'b1;
            end else begin
                s_rvalid[r_idx] = m_rvalid;
                m_rready        = s_rready[r_idx];
            end
        end
    end

    assign r_last_hs = m_rvalid && m_rready && m_rlast && !r_bad;

    always_comb begin
        cnt_inc   = '0;
        cnt_dec   = '0;
        underflow = 1'b0;
        if (ar_hs) cnt_inc[grant] = 1'b1;
        if (r_last_hs) cnt_dec[r_idx] = 1'b1;
        for (int k = 0; k < NUM_MST; k++) begin
            if (cnt_dec[k] && !cnt_inc[k] && cnt[k] == '0) underflow = 1'b1;
        end
    end

    // An AR accept and an rlast on the same master in one cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_MST; k++) cnt[k] <= '0;
            err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_MST; k++) begin
                if (cnt_inc[k] && !cnt_dec[k]) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end else if (cnt_dec[k] && !cnt_inc[k] && cnt[k] != '0) begin
                    cnt[k] <= cnt[k] - CNT_W'(1);
                end
            end
            if (underflow || (m_rvalid && r_bad)) err <= 1'b1;
        end
    end

    always_comb begin
        ost_cnt = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            ost_cnt[k*CNT_W +: CNT_W] = cnt[k];
        end
    end

endmodule
